// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// opcode decode constant, timeout default and the Moore output decode.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_F1   = 3'd1,
        ST_F2   = 3'd2,
        ST_EXEC = 3'd3,
        ST_ERR  = 3'd4
    } fetch_state_t;

    // Opcode bit that flags a second (address) byte
    localparam int TWO_BYTE_BIT     = 7;
    localparam int MAX_WAIT_DEFAULT = 8;

    typedef struct packed {
        logic       mem_rd_req;
        logic [7:0] mem_addr;
        logic       ir2_rd_en;
        logic       busy;
        logic       err;
    } moore_out_t;

    // Output values that belong to a state; evaluated on the next state so
    // the outputs can be registered without a cycle of lag.
    function automatic moore_out_t moore_outputs(input fetch_state_t st,
                                                 input logic [7:0]   addr,
                                                 input logic         two_byte);
        moore_out_t mo;
        mo.mem_rd_req = (st == ST_F1) || (st == ST_F2);
        mo.mem_addr   = mo.mem_rd_req ? addr : 8'h00;
        mo.ir2_rd_en  = (st == ST_EXEC) && two_byte;
        mo.busy       = (st != ST_IDLE);
        mo.err        = (st == ST_ERR);
        return mo;
    endfunction

endpackage

// File: rtl/fetch_sequencer_wait_timer.sv
// Memory-acknowledge wait counter: clear restarts it, enable counts one
// cycle, expired flags the last permitted wait cycle.
module wait_timer #(
    parameter int MAX_WAIT = 8
) (
    input  logic IR_2_clk,
    input  logic IR_2_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] wait_cnt_reg;

    always_ff @(posedge IR_2_clk or posedge IR_2_rst) begin
        if (IR_2_rst) begin
            wait_cnt_reg <= '0;
        end else if (clear) begin
            wait_cnt_reg <= '0;
        end else if (enable && (wait_cnt_reg != LAST)) begin
            // Saturating: the FSM leaves for ERR once LAST is seen unacked
            wait_cnt_reg <= wait_cnt_reg + CW'(1);
        end
    end

    assign expired = (wait_cnt_reg == LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// One- or two-byte instruction fetch controller: reads the opcode, optionally
// the address byte, hands off to execute and times out on a silent memory.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic       IR_2_clk,
    input  logic       IR_2_rst,
    input  logic       start,
    input  logic [7:0] pc_in,
    output logic       mem_rd_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic       ir1_wr_en,
    output logic       ir2_wr_en,
    output logic       ir2_rd_en,
    output logic       pc_inc,
    output logic       fetch_done,
    input  logic       exec_done,
    output logic       busy,
    output logic       err,
    input  logic       clear_err
);

    fetch_state_t state_reg, state_next;
    logic [7:0]   addr_q, addr_next;
    logic         two_byte_reg, two_byte_next;
    logic         timer_clear, timer_en, timer_expired;
    moore_out_t   mo_next;

    wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .IR_2_clk (IR_2_clk),
        .IR_2_rst (IR_2_rst),
        .clear    (timer_clear),
        .enable   (timer_en),
        .expired  (timer_expired)
    );

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_q;
        two_byte_next = two_byte_reg;
        timer_clear   = 1'b0;
        timer_en      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    addr_next   = pc_in;
                    timer_clear = 1'b1;
                    state_next  = ST_F1;
                end
            end
            ST_F1: begin
                if (mem_ack) begin
                    two_byte_next = mem_rdata[TWO_BYTE_BIT];
                    if (mem_rdata[TWO_BYTE_BIT]) begin
                        addr_next   = addr_q + 8'd1;
                        timer_clear = 1'b1;
                        state_next  = ST_F2;
                    end else begin
                        state_next  = ST_EXEC;
                    end
                end else if (timer_expired) begin
                    state_next = ST_ERR;
                end else begin
                    timer_en = 1'b1;
                end
            end
            ST_F2: begin
                // An acknowledge on the last wait cycle still completes
                if (mem_ack) begin
                    state_next = ST_EXEC;
                end else if (timer_expired) begin
                    state_next = ST_ERR;
                end else begin
                    timer_en = 1'b1;
                end
            end
            ST_EXEC: begin
                if (exec_done) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (clear_err) begin
                    two_byte_next = 1'b0;
                    state_next    = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign mo_next = moore_outputs(state_next, addr_next, two_byte_next);

    always_ff @(posedge IR_2_clk or posedge IR_2_rst) begin
        if (IR_2_rst) begin
            state_reg    <= ST_IDLE;
            addr_q       <= 8'h00;
            two_byte_reg <= 1'b0;
            mem_rd_req   <= 1'b0;
            mem_addr     <= 8'h00;
            ir2_rd_en    <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            fetch_done   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_q       <= addr_next;
            two_byte_reg <= two_byte_next;
            mem_rd_req   <= mo_next.mem_rd_req;
            mem_addr     <= mo_next.mem_addr;
            ir2_rd_en    <= mo_next.ir2_rd_en;
            busy         <= mo_next.busy;
            err          <= mo_next.err;
            fetch_done   <= (state_next == ST_EXEC) && (state_reg != ST_EXEC);
        end
    end

    // Byte-capture strobes respond to mem_ack in the same cycle
    assign ir1_wr_en = (state_reg == ST_F1) && mem_ack;
    assign ir2_wr_en = (state_reg == ST_F2) && mem_ack;
    assign pc_inc    = ir1_wr_en || ir2_wr_en;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus randomized fetch scenarios, each checked cycle by cycle
// against the expected bus behaviour of an instruction fetch.
module tb_fetch_sequencer;

    localparam int MAX_WAIT = 8;

    logic       IR_2_clk = 1'b0;
    logic       IR_2_rst;
    logic       start;
    logic [7:0] pc_in;
    logic       mem_rd_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       ir1_wr_en;
    logic       ir2_wr_en;
    logic       ir2_rd_en;
    logic       pc_inc;
    logic       fetch_done;
    logic       exec_done;
    logic       busy;
    logic       err;
    logic       clear_err;

    int checks = 0;
    int errors = 0;
    int pc_inc_cnt;

    fetch_sequencer #(.MAX_WAIT(MAX_WAIT)) dut (
        .IR_2_clk   (IR_2_clk),
        .IR_2_rst   (IR_2_rst),
        .start      (start),
        .pc_in      (pc_in),
        .mem_rd_req (mem_rd_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .ir1_wr_en  (ir1_wr_en),
        .ir2_wr_en  (ir2_wr_en),
        .ir2_rd_en  (ir2_rd_en),
        .pc_inc     (pc_inc),
        .fetch_done (fetch_done),
        .exec_done  (exec_done),
        .busy       (busy),
        .err        (err),
        .clear_err  (clear_err)
    );

    always #5 IR_2_clk = ~IR_2_clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_req"},   mem_rd_req, 1'b0);
        chk8({tag, "_addr"},  mem_addr,   8'h00);
        chk1({tag, "_wr1"},   ir1_wr_en,  1'b0);
        chk1({tag, "_wr2"},   ir2_wr_en,  1'b0);
        chk1({tag, "_rd2"},   ir2_rd_en,  1'b0);
        chk1({tag, "_pcinc"}, pc_inc,     1'b0);
        chk1({tag, "_done"},  fetch_done, 1'b0);
        chk1({tag, "_busy"},  busy,       1'b0);
        chk1({tag, "_err"},   err,        1'b0);
    endtask

    // One byte request: memory answers after 'delay' wait cycles, or never
    // when delay >= MAX_WAIT (ok stays 0 after MAX_WAIT request cycles).
    task automatic phase(input logic [7:0] addr, input logic [7:0] data,
                         input int delay, input bit second, output bit ok);
        bit hit;
        ok = 1'b0;
        for (int w = 0; w < MAX_WAIT; w++) begin
            @(negedge IR_2_clk);
            hit       = (w == delay);
            start     = 1'b0;
            pc_in     = 8'($urandom);
            mem_ack   = hit;
            mem_rdata = hit ? data : 8'($urandom);
            #1;
            chk1("req",   mem_rd_req, 1'b1);
            chk8("addr",  mem_addr,   addr);
            chk1("wr1",   ir1_wr_en,  hit && !second);
            chk1("wr2",   ir2_wr_en,  hit && second);
            chk1("pcinc", pc_inc,     hit);
            chk1("err",   err,        1'b0);
            if (pc_inc) pc_inc_cnt++;
            if (hit) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic timeout_recover();
        @(negedge IR_2_clk);
        mem_ack = 1'b0;
        #1;
        chk1("to_err",  err,        1'b1);
        chk1("to_busy", busy,       1'b1);
        chk1("to_req",  mem_rd_req, 1'b0);
        chk8("to_addr", mem_addr,   8'h00);
        for (int i = 0; i < 2; i++) begin
            @(negedge IR_2_clk);
            mem_ack = 1'($urandom);
            start   = 1'b1;
            #1;
            chk1("to_hold", err, 1'b1);
        end
        @(negedge IR_2_clk);
        start = 1'b0; mem_ack = 1'b0; clear_err = 1'b1;
        #1;
        chk1("to_clr_cycle", err, 1'b1);
        @(negedge IR_2_clk);
        clear_err = 1'b0;
        #1;
        chk1("rec_err",  err,       1'b0);
        chk1("rec_busy", busy,      1'b0);
        chk1("rec_rd2",  ir2_rd_en, 1'b0);
    endtask

    task automatic fetch(input logic [7:0] pc, input logic [7:0] b1, input logic [7:0] b2,
                         input int d1, input int d2, input int ew);
        bit ok;
        logic two;
        two = b1[7];
        pc_inc_cnt = 0;
        @(negedge IR_2_clk);
        start = 1'b1; pc_in = pc;
        #1;
        chk1("idle_busy", busy,       1'b0);
        chk1("idle_req",  mem_rd_req, 1'b0);
        phase(pc, b1, d1, 1'b0, ok);
        if (!ok) begin
            timeout_recover();
            $display("fetch pc=%02h op=%02h d1=%0d -> timeout in opcode fetch", pc, b1, d1);
            return;
        end
        if (two) begin
            phase(pc + 8'd1, b2, d2, 1'b1, ok);
            if (!ok) begin
                timeout_recover();
                $display("fetch pc=%02h op=%02h d2=%0d -> timeout in address fetch", pc, b1, d2);
                return;
            end
        end
        for (int e = 0; e <= ew; e++) begin
            @(negedge IR_2_clk);
            mem_ack   = 1'($urandom);
            mem_rdata = 8'($urandom);
            start     = (e == ew) ? 1'b1 : 1'($urandom);
            exec_done = (e == ew);
            #1;
            chk1("ex_done",  fetch_done, e == 0);
            chk1("ex_req",   mem_rd_req, 1'b0);
            chk8("ex_addr",  mem_addr,   8'h00);
            chk1("ex_rd2",   ir2_rd_en,  two);
            chk1("ex_busy",  busy,       1'b1);
            chk1("ex_pcinc", pc_inc,     1'b0);
            chk1("ex_wr1",   ir1_wr_en,  1'b0);
            chk1("ex_wr2",   ir2_wr_en,  1'b0);
        end
        @(negedge IR_2_clk);
        start = 1'b0; exec_done = 1'b0; mem_ack = 1'b0;
        #1;
        chk1("end_busy", busy,       1'b0);
        chk1("end_req",  mem_rd_req, 1'b0);
        chk1("end_rd2",  ir2_rd_en,  1'b0);
        chk8("pcinc_cnt", 8'(pc_inc_cnt), two ? 8'd2 : 8'd1);
        $display("fetch pc=%02h op=%02h arg=%02h d1=%0d d2=%0d exec=%0d bytes=%0d",
                 pc, b1, b2, d1, d2, ew, two ? 2 : 1);
    endtask

    initial begin
        bit ok;
        IR_2_rst = 1'b1;
        start = 1'b0; pc_in = 8'h00; mem_ack = 1'b0; mem_rdata = 8'h00;
        exec_done = 1'b0; clear_err = 1'b0;
        #1;
        chk_all_zero("rst");
        @(negedge IR_2_clk);
        @(negedge IR_2_clk);
        IR_2_rst = 1'b0;
        #1;
        chk_all_zero("post_rst");

        fetch(8'h10, 8'h05, 8'h00, 2, 0, 1);
        fetch(8'hFF, 8'h83, 8'h3C, 1, 2, 2);
        fetch(8'h20, 8'h01, 8'h00, MAX_WAIT, 0, 0);
        fetch(8'h30, 8'h06, 8'h00, MAX_WAIT - 1, 0, 0);
        fetch(8'h50, 8'hC0, 8'h11, 0, MAX_WAIT, 0);
        fetch(8'h60, 8'hA5, 8'h22, 3, MAX_WAIT - 1, 0);

        // Reset while the address byte is outstanding, with an ack in flight
        pc_inc_cnt = 0;
        @(negedge IR_2_clk);
        start = 1'b1; pc_in = 8'h40;
        phase(8'h40, 8'h9A, 0, 1'b0, ok);
        @(negedge IR_2_clk);
        mem_ack = 1'b0;
        #1;
        chk8("f2_addr", mem_addr, 8'h41);
        #2;
        mem_ack = 1'b1;
        #1;
        chk1("pre_rst_wr2", ir2_wr_en, 1'b1);
        IR_2_rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        @(negedge IR_2_clk);
        mem_ack = 1'b0;
        IR_2_rst = 1'b0;
        #1;
        chk_all_zero("mid_rst_rel");
        $display("reset during address fetch at pc=40");
        fetch(8'h77, 8'h12, 8'h00, 1, 0, 0);

        for (int n = 0; n < 20; n++) begin
            fetch(8'($urandom), 8'($urandom), 8'($urandom),
                  $urandom_range(0, MAX_WAIT + 1), $urandom_range(0, MAX_WAIT + 1),
                  $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 8, meaning the maximum number of cycles a memory request waits for mem_ack before the error state.
REQ-002 SHALL have port IR_2_clk, input, 1, clock; all state updates occur on its rising edge.
REQ-003 SHALL have port IR_2_rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to fetch one instruction; sampled only in IDLE.
REQ-005 SHALL have port pc_in, input, 8, program counter value at start.
REQ-006 SHALL have port mem_rd_req, output, 1, memory read request.
REQ-007 SHALL have port mem_addr, output, 8, memory read address.
REQ-008 SHALL have port mem_ack, input, 1, memory read data is valid this cycle.
REQ-009 SHALL have port mem_rdata, input, 8, memory read data; external wiring also feeds it to both instruction registers.
REQ-010 SHALL have port ir1_wr_en, output, 1, write enable for the opcode register.
REQ-011 SHALL have port ir2_wr_en, output, 1, write enable for the address-byte register (IR_2_wr_en).
REQ-012 SHALL have port ir2_rd_en, output, 1, read enable for the address-byte register (IR_2_rd_en).
REQ-013 SHALL have port pc_inc, output, 1, one-cycle pulse to increment the PC per byte fetched.
REQ-014 SHALL have port fetch_done, output, 1, one-cycle pulse when the instruction is complete.
REQ-015 SHALL have port exec_done, input, 1, the execute unit has finished the instruction.
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-017 SHALL have port err, output, 1, high in ERR.
REQ-018 SHALL have port clear_err, input, 1, leaves ERR.

Function
REQ-019 SHALL implement the states IDLE, F1, F2, EXEC and ERR.
REQ-020 SHALL, in IDLE with start=1, capture pc_in into addr_q, clear wait_cnt and enter F1 on the next edge.
REQ-021 SHALL drive mem_rd_req=1 and mem_addr=addr_q in F1 and F2 (Moore), and drive mem_rd_req=0 and mem_addr=8'h00 in all other states.
REQ-022 SHALL, in F1 with mem_ack=1, assert ir1_wr_en=1 and pc_inc=1 in that same cycle (Mealy), and latch two_byte=mem_rdata[7].
REQ-023 SHALL, at the end of F1, go to F2 if mem_rdata[7]=1, with addr_q+1 modulo 256 (8'hFF wraps to 8'h00) and wait_cnt cleared.
REQ-024 SHALL, at the end of F1, go to EXEC if mem_rdata[7]=0.
REQ-025 SHALL, in F2 with mem_ack=1, assert ir2_wr_en=1 and pc_inc=1 in the same cycle, then enter EXEC.
REQ-026 SHALL assert fetch_done for exactly the first cycle of EXEC.
REQ-027 SHALL hold ir2_rd_en=two_byte throughout EXEC and 0 elsewhere.
REQ-028 SHALL, in EXEC with exec_done=1, go to IDLE; start in that cycle is ignored.
REQ-029 SHALL increment wait_cnt in F1/F2 each cycle mem_ack=0, and enter ERR when wait_cnt reaches MAX_WAIT-1 with mem_ack=0; mem_ack=1 in that cycle wins.
REQ-030 SHALL hold err=1 in ERR until clear_err=1, then go to IDLE with two_byte=0.
REQ-031 SHALL ignore mem_ack outside F1/F2, start outside IDLE, and exec_done outside EXEC.
REQ-032 SHALL have a single-byte fetch latency of 1 cycle after mem_ack to fetch_done and a two-byte latency of 2 cycles minimum after start to F2.

Reset
REQ-033 SHALL, on IR_2_rst=1 at any time including mid-fetch, immediately force state=IDLE, addr_q=0, wait_cnt=0, two_byte=0 and every output 0.

Structure
REQ-034 SHALL place the state encoding, the TWO_BYTE_BIT=7 constant and the MAX_WAIT default in a shared package fetch_pkg.
REQ-035 SHALL use one sub-module, wait_timer (wait_cnt with clear/enable/expired), and keep everything else flat.

Verification
REQ-036 SHALL cover: pc_in=8'h10, start, ack after 2 cycles with rdata=8'h05 -> single ir1_wr_en, pc_inc once, fetch_done, ir2_rd_en=0, no F2.
REQ-037 SHALL cover: pc_in=8'hFF, rdata1=8'h83, rdata2=8'h3C -> F2 mem_addr=8'h00, ir2_wr_en once, ir2_rd_en=1 until exec_done, pc_inc twice.
REQ-038 SHALL cover: MAX_WAIT=8, no ack -> err=1 after 8 request cycles; clear_err -> IDLE, busy=0.
REQ-039 SHALL cover: ack on the 8th wait cycle -> normal completion, err stays 0.
REQ-040 SHALL cover: IR_2_rst asserted in F2 -> all outputs 0 immediately; next start fetches from new pc_in.
REQ-041 SHALL cover: start and mem_ack pulsed in EXEC -> no new request until IDLE.
